tt_tx_scheduler: RTL and testbench

- Time-triggered transmit scheduler that sequences the GMII UDP frame sender.
- Runs a programmable cyclic timer and holds a slot table. Each slot gives a send offset, a RAM base address, a destination-MAC select and a UDP length.
- At each slot's offset it requests one frame from the sender. It tracks completion and counts slots that are missed because the sender was still busy.
- Sits between the CPU-side configuration logic and the frame sender; replaces the sender's free-running inter-frame delay.

---
 rtl/tt_sched_pkg.sv | 15 +
 rtl/tt_cycle_timer.sv | 20 ++
 rtl/tt_tx_scheduler.sv | 83 ++++++++
 tb/tb_tt_tx_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sched_pkg.sv
// tt_sched_pkg: shared types and constants for the time-triggered transmit scheduler
package tt_sched_pkg;
  typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;
  localparam int PKG_ADDR_W = 9;
  localparam int PKG_DEST_W = 2;
  localparam logic [15:0] MISS_SAT = 16'hFFFF;
  localparam logic [31:0] MIN_CYCLE_LEN = 32'd16;
  typedef struct packed {
    logic                  en;
    logic [31:0]           offset;
    logic [PKG_ADDR_W-1:0] base;
    logic [PKG_DEST_W-1:0] dest;
    logic [15:0]           len;
  } slot_t;
endpackage

// File: rtl/tt_cycle_timer.sv
// tt_cycle_timer: cyclic timer with wrap pulse and completed-cycle counter
module tt_cycle_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] cycle_len,
  output logic [31:0] timer,
  output logic        wrap,
  output logic [15:0] cycle_count
);
  assign wrap = enable && timer >= cycle_len - 32'd1;
  always_ff @(posedge clk)
    if (!rst_n) begin
      timer       <= '0;
      cycle_count <= '0;
    end else begin
      timer       <= (!enable || wrap) ? '0 : timer + 32'd1;
      cycle_count <= cycle_count + {15'd0, wrap};
    end
endmodule

// File: rtl/tt_tx_scheduler.sv
// tt_tx_scheduler: slot table, scan pointer and request handshake toward the frame sender
module tt_tx_scheduler
  import tt_sched_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = 3,
  parameter int ADDR_W    = PKG_ADDR_W,
  parameter int DEST_W    = PKG_DEST_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [31:0]       cycle_len,
  input  logic              cfg_we,
  input  logic [SLOT_W-1:0] cfg_slot,
  input  logic              cfg_en,
  input  logic [31:0]       cfg_offset,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [DEST_W-1:0] cfg_dest,
  input  logic [15:0]       cfg_len,
  output logic              tx_req,
  output logic [ADDR_W-1:0] tx_base_addr,
  output logic [DEST_W-1:0] tx_dest_sel,
  output logic [15:0]       tx_data_length,
  input  logic              tx_ack,
  input  logic              tx_done,
  output logic              busy,
  output logic [SLOT_W-1:0] cur_slot,
  output logic [15:0]       cycle_count,
  output logic [15:0]       miss_count
);
  logic [31:0]       timer;
  logic              wrap;
  logic              match;
  logic [SLOT_W-1:0] ptr;
  slot_t             slots [NUM_SLOTS];
  slot_t             cur;
  state_t            state, state_nxt;
  tt_cycle_timer u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .cycle_len   (cycle_len),
    .timer       (timer),
    .wrap        (wrap),
    .cycle_count (cycle_count)
  );
  assign cur    = slots[ptr];
  assign tx_req = state == REQ;
  assign busy   = state != IDLE;
  always_comb begin
    match     = enable && cur.en && timer == cur.offset;
    state_nxt = state == IDLE ? (match ? REQ : IDLE) :
                state == REQ  ? (tx_ack ? (tx_done ? IDLE : BUSY) : REQ) :
                                (tx_done ? IDLE : BUSY);
  end
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nxt;
  always_ff @(posedge clk)
    if (!rst_n)
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
    else if (cfg_we)
      slots[cfg_slot] <= '{en: cfg_en, offset: cfg_offset, base: PKG_ADDR_W'(cfg_base),
                           dest: PKG_DEST_W'(cfg_dest), len: cfg_len};
  always_ff @(posedge clk)
    if (!rst_n || !enable || wrap) ptr <= '0;
    else if ((!cur.en || match) && ptr != SLOT_W'(NUM_SLOTS - 1)) ptr <= ptr + 1'b1;
  always_ff @(posedge clk)
    if (!rst_n) begin
      tx_base_addr   <= '0;
      tx_dest_sel    <= '0;
      tx_data_length <= '0;
      cur_slot       <= '0;
    end else if (state == IDLE && match) begin
      tx_base_addr   <= ADDR_W'(cur.base);
      tx_dest_sel    <= DEST_W'(cur.dest);
      tx_data_length <= cur.len;
      cur_slot       <= ptr;
    end
  always_ff @(posedge clk)
    if (!rst_n) miss_count <= '0;
    else if (match && state != IDLE && miss_count != MISS_SAT) miss_count <= miss_count + 16'd1;
endmodule

// File: tb/tb_tt_tx_scheduler.sv
// tb_tt_tx_scheduler: directed stimulus with a behavioural schedule model compared every cycle
module tb_tt_tx_scheduler;
  logic        clk, rst_n, enable, cfg_we, cfg_en, tx_ack, tx_done;
  logic [31:0] cycle_len, cfg_offset;
  logic [2:0]  cfg_slot, cur_slot;
  logic [8:0]  cfg_base, tx_base_addr;
  logic [1:0]  cfg_dest, tx_dest_sel;
  logic [15:0] cfg_len, tx_data_length, cycle_count, miss_count;
  logic        tx_req, busy;
  int checks = 0, passed = 0;
  bit chk_on = 0;
  bit          t_en [8];
  logic [31:0] t_off [8];
  logic [8:0]  t_base [8];
  logic [1:0]  t_dest [8];
  logic [15:0] t_len [8];
  logic [31:0] m_tmr;
  int          m_ptr;
  bit          m_req, m_busy, m_match, m_wrap, m_was;
  logic [8:0]  m_base;
  logic [1:0]  m_dest;
  logic [15:0] m_len, m_cc, m_miss;
  logic [2:0]  m_slot;
  int  cnt = 0, ack_dly = 2, done_dly = 60;
  bit  both = 0;
  tt_tx_scheduler dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cycle_len(cycle_len),
    .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_en(cfg_en), .cfg_offset(cfg_offset),
    .cfg_base(cfg_base), .cfg_dest(cfg_dest), .cfg_len(cfg_len),
    .tx_req(tx_req), .tx_base_addr(tx_base_addr), .tx_dest_sel(tx_dest_sel),
    .tx_data_length(tx_data_length), .tx_ack(tx_ack), .tx_done(tx_done),
    .busy(busy), .cur_slot(cur_slot), .cycle_count(cycle_count), .miss_count(miss_count)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        t_en[i] = 0; t_off[i] = 0; t_base[i] = 0; t_dest[i] = 0; t_len[i] = 0;
      end
      m_tmr = 0; m_ptr = 0; m_req = 0; m_busy = 0; m_base = 0; m_dest = 0;
      m_len = 0; m_slot = 0; m_cc = 0; m_miss = 0;
    end else begin
      m_match = enable && t_en[m_ptr] && m_tmr == t_off[m_ptr];
      m_wrap  = enable && m_tmr >= cycle_len - 1;
      m_was   = m_busy;
      if (m_match && m_was && m_miss != 16'hFFFF) m_miss = m_miss + 1;
      if (!m_was && m_match) begin
        m_req = 1; m_busy = 1; m_slot = 3'(m_ptr);
        m_base = t_base[m_ptr]; m_dest = t_dest[m_ptr]; m_len = t_len[m_ptr];
      end else if (m_req && tx_ack) begin
        m_req = 0; m_busy = !tx_done;
      end else if (m_was && !m_req && tx_done) m_busy = 0;
      if (!enable || m_wrap) m_ptr = 0;
      else if ((!t_en[m_ptr] || m_match) && m_ptr < 7) m_ptr++;
      m_tmr = (!enable || m_wrap) ? 0 : m_tmr + 1;
      if (m_wrap) m_cc = m_cc + 1;
      if (cfg_we) begin
        t_en[cfg_slot] = cfg_en; t_off[cfg_slot] = cfg_offset; t_base[cfg_slot] = cfg_base;
        t_dest[cfg_slot] = cfg_dest; t_len[cfg_slot] = cfg_len;
      end
    end
  end
  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      chk("cmp_tx_req", tx_req, m_req);
      chk("cmp_busy", busy, m_busy);
      chk("cmp_cur_slot", cur_slot, m_slot);
      chk("cmp_cycle_count", cycle_count, m_cc);
      chk("cmp_miss_count", miss_count, m_miss);
      if (m_req) begin
        chk("cmp_base", tx_base_addr, m_base);
        chk("cmp_dest", tx_dest_sel, m_dest);
        chk("cmp_len", tx_data_length, m_len);
      end
    end
  end
  always @(negedge clk) begin
    tx_ack = 0;
    tx_done = 0;
    if (m_req) begin
      if (cnt == ack_dly) begin tx_ack = 1; tx_done = both; cnt = 0; end
      else cnt++;
    end else if (m_busy) begin
      if (cnt == done_dly) begin tx_done = 1; cnt = 0; end
      else cnt++;
    end else cnt = 0;
  end
  task automatic wr(input int s, input bit e, input int off, input int b, input int d, input int l);
    @(negedge clk);
    cfg_we = 1; cfg_slot = 3'(s); cfg_en = e; cfg_offset = off;
    cfg_base = 9'(b); cfg_dest = 2'(d); cfg_len = 16'(l);
    @(negedge clk);
    cfg_we = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; enable = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask
  task automatic wait_req(output int n);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      n++;
      if (tx_req) break;
    end
    chk("req_seen", tx_req, 1);
  endtask
  initial begin
    int n, rises, hi;
    bit prev;
    rst_n = 0; enable = 0; cycle_len = 100; cfg_we = 0; cfg_slot = 0; cfg_en = 0;
    cfg_offset = 0; cfg_base = 0; cfg_dest = 0; cfg_len = 0;
    repeat (3) @(negedge clk);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_base", tx_base_addr, 0);
    chk("rst_len", tx_data_length, 0);
    chk("rst_counts", {cycle_count, miss_count, 13'd0, cur_slot}, 0);
    rst_n = 1;
    chk_on = 1;
    wr(0, 1, 10, 1, 0, 40);
    enable = 1;
    wait_req(n);
    chk("t1_req_edge", n, 11);
    chk("t1_base", tx_base_addr, 1);
    chk("t1_dest", tx_dest_sel, 0);
    chk("t1_len", tx_data_length, 40);
    rises = 0; prev = 1;
    repeat (250) begin
      @(posedge clk); #1;
      if (tx_req && !prev) rises++;
      prev = tx_req;
    end
    chk("t1_repeat", rises, 2);
    chk("t1_miss", miss_count, 0);
    do_reset();
    done_dly = 48;
    wr(0, 1, 10, 3, 1, 50);
    wr(1, 1, 30, 4, 2, 60);
    enable = 1;
    wait_req(n);
    repeat (289) @(posedge clk);
    #1;
    chk("t2_miss", miss_count, 3);
    chk("t2_cur_slot", cur_slot, 0);
    do_reset();
    ack_dly = 1; done_dly = 5;
    cycle_len = 20;
    wr(1, 1, 1, 5, 2, 77);
    enable = 1;
    wait_req(n);
    chk("t3_req_edge", n, 2);
    chk("t3_payload", {tx_base_addr, tx_dest_sel, tx_data_length}, {9'd5, 2'd2, 16'd77});
    chk("t3_cur_slot", cur_slot, 1);
    rises = 0; prev = 1;
    repeat (60) begin
      @(posedge clk); #1;
      if (tx_req && !prev) rises++;
      prev = tx_req;
    end
    chk("t3_repeat", rises, 3);
    chk("t3_cycles", cycle_count, 3);
    do_reset();
    ack_dly = 40; done_dly = 10;
    cycle_len = 100;
    wr(0, 1, 5, 9, 1, 123);
    enable = 1;
    wait_req(n);
    hi = 1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (!tx_req) break;
      hi++;
    end
    chk("t4_req_hold", hi, 41);
    chk("t4_busy_after_ack", busy, 1);
    @(negedge clk);
    enable = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
    chk("t5_done_idle", busy, 0);
    rises = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (tx_req) rises++;
    end
    chk("t5_no_req", rises, 0);
    @(negedge clk);
    enable = 1;
    wait_req(n);
    @(negedge clk);
    rst_n = 0;
    @(posedge clk); #1;
    chk("t5_rst_req", {tx_req, busy}, 0);
    chk("t5_rst_payload", {tx_base_addr, tx_dest_sel, tx_data_length}, 0);
    chk("t5_rst_counts", {cycle_count, miss_count, 13'd0, cur_slot}, 0);
    @(negedge clk);
    rst_n = 1;
    do_reset();
    ack_dly = 1; both = 1;
    wr(0, 1, 3, 7, 3, 9);
    enable = 1;
    wait_req(n);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!tx_req) break;
    end
    chk("t6_ack_done_idle", busy, 0);
    do_reset();
    both = 0; ack_dly = 1000000;
    cycle_len = 1000;
    enable = 1;
    for (int i = 0; i < 70000 && m_miss != 16'hFFFF; i++) begin
      @(negedge clk);
      cfg_we = 1; cfg_slot = 7; cfg_en = 1; cfg_offset = m_tmr + 1;
      cfg_base = 2; cfg_dest = 1; cfg_len = 3;
    end
    repeat (20) begin
      @(negedge clk);
      cfg_we = 1; cfg_slot = 7; cfg_en = 1; cfg_offset = m_tmr + 1;
    end
    @(negedge clk);
    cfg_we = 0;
    chk("t7_miss_sat", miss_count, 16'hFFFF);
    chk("t7_still_req", tx_req, 1);
    chk_on = 0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
